cache_refill_unit: RTL and testbench

- Miss-handling engine between the cache control FSM and the memory bus interface; drives one CacheLine-style line port (tag/valid/dirty + 2^OFFSET_WIDTH words, registered read with 1-cycle latency).
- On a miss, writes back the victim line if it is dirty, then refills the line with a burst read.
- Pulses done once the line is valid and clean with the new tag.

---
 rtl/cache_refill_unit.sv | 176 +++++++++++++++++
 tb/tb_cache_refill_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_unit.sv
// Cache miss engine: on a miss, writes back the victim line if it is dirty,
// then refills the line with a burst read and pulses done.
module cache_refill_unit #(
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [31:0]             miss_addr,
    input  logic                    victim_dirty,
    input  logic [TAG_WIDTH-1:0]    victim_tag,
    output logic                    busy,
    output logic                    done,
    output logic                    line_write_en,
    output logic                    line_valid_in,
    output logic                    line_dirty_in,
    output logic [TAG_WIDTH-1:0]    line_tag_in,
    output logic [OFFSET_WIDTH-1:0] line_offset,
    output logic [3:0]              line_byte_en,
    output logic [31:0]             line_data_in,
    input  logic [31:0]             line_data_out,
    output logic                    mem_rd_req,
    output logic [31:0]             mem_rd_addr,
    input  logic                    mem_rd_ready,
    input  logic                    mem_rd_valid,
    input  logic [31:0]             mem_rd_data,
    output logic                    mem_wr_req,
    output logic [31:0]             mem_wr_addr,
    input  logic                    mem_wr_ready,
    output logic                    mem_wr_valid,
    output logic [31:0]             mem_wr_data,
    output logic                    mem_wr_last,
    input  logic                    mem_wr_data_ready,
    input  logic                    mem_wr_done
);

    localparam int LINE_ADDR_W = TAG_WIDTH + INDEX_WIDTH;
    localparam int LOW_W       = OFFSET_WIDTH + 2;
    localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [OFFSET_WIDTH-1:0] CNT_ONE  = OFFSET_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, WB_ADDR, WB_RD, WB_DATA, WB_RESP, RF_ADDR, RF_DATA, DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [OFFSET_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LINE_ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [TAG_WIDTH-1:0]     victim_tag_q, victim_tag_d;
    logic [31:0]              wbuf_q, wbuf_d;
    logic                     wb_first_q, wb_first_d;

    logic [TAG_WIDTH-1:0]     new_tag;
    logic [INDEX_WIDTH-1:0]   index;
    logic                     unused_addr_bits;

    assign new_tag          = line_addr_q[LINE_ADDR_W-1:INDEX_WIDTH];
    assign index            = line_addr_q[INDEX_WIDTH-1:0];
    assign unused_addr_bits = ^miss_addr[LOW_W-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_addr_q  <= '0;
            victim_tag_q <= '0;
            wbuf_q       <= '0;
            wb_first_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_addr_q  <= line_addr_d;
            victim_tag_q <= victim_tag_d;
            wbuf_q       <= wbuf_d;
            wb_first_q   <= wb_first_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_addr_d   = line_addr_q;
        victim_tag_d  = victim_tag_q;
        wbuf_d        = wbuf_q;
        wb_first_d    = 1'b0;

        busy          = (state_q != IDLE);
        done          = 1'b0;
        line_write_en = 1'b0;
        line_valid_in = 1'b0;
        line_dirty_in = 1'b0;
        line_tag_in   = '0;
        line_offset   = '0;
        line_byte_en  = 4'h0;
        line_data_in  = '0;
        mem_rd_req    = 1'b0;
        mem_rd_addr   = '0;
        mem_wr_req    = 1'b0;
        mem_wr_addr   = '0;
        mem_wr_valid  = 1'b0;
        mem_wr_data   = '0;
        mem_wr_last   = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    line_addr_d  = miss_addr[31:LOW_W];
                    victim_tag_d = victim_tag;
                    cnt_d        = '0;
                    state_d      = victim_dirty ? WB_ADDR : RF_ADDR;
                end
            end
            WB_ADDR: begin
                mem_wr_req  = 1'b1;
                mem_wr_addr = {victim_tag_q, index, {LOW_W{1'b0}}};
                if (mem_wr_ready) state_d = WB_RD;
            end
            WB_RD: begin
                line_offset = cnt_q;
                wb_first_d  = 1'b1;
                state_d     = WB_DATA;
            end
            WB_DATA: begin
                // Read data is live only in the first cycle; afterwards the
                // captured copy keeps the beat stable under backpressure.
                mem_wr_valid = 1'b1;
                mem_wr_data  = wb_first_q ? line_data_out : wbuf_q;
                mem_wr_last  = (cnt_q == CNT_LAST);
                if (wb_first_q) wbuf_d = line_data_out;
                if (mem_wr_data_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = WB_RESP;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = WB_RD;
                    end
                end
            end
            WB_RESP: begin
                if (mem_wr_done) begin
                    cnt_d   = '0;
                    state_d = RF_ADDR;
                end
            end
            RF_ADDR: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = {line_addr_q, {LOW_W{1'b0}}};
                if (mem_rd_ready) state_d = RF_DATA;
            end
            RF_DATA: begin
                if (mem_rd_valid) begin
                    line_write_en = 1'b1;
                    line_offset   = cnt_q;
                    line_data_in  = mem_rd_data;
                    line_byte_en  = 4'hf;
                    line_tag_in   = new_tag;
                    line_valid_in = (cnt_q == CNT_LAST);
                    cnt_d         = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Bench for cache_refill_unit: line RAM and bus responder models, a per-cycle
// compare process against a transaction-level model, and directed scenarios.
module tb_cache_refill_unit;

    localparam int TW = 20;
    localparam int IW = 6;
    localparam int OW = 4;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          miss_req;
    logic [31:0]   miss_addr;
    logic          victim_dirty;
    logic [TW-1:0] victim_tag;
    logic          busy, done;
    logic          line_write_en, line_valid_in, line_dirty_in;
    logic [TW-1:0] line_tag_in;
    logic [OW-1:0] line_offset;
    logic [3:0]    line_byte_en;
    logic [31:0]   line_data_in, line_data_out;
    logic          mem_rd_req, mem_rd_ready, mem_rd_valid;
    logic [31:0]   mem_rd_addr, mem_rd_data;
    logic          mem_wr_req, mem_wr_ready, mem_wr_valid, mem_wr_last;
    logic          mem_wr_data_ready, mem_wr_done;
    logic [31:0]   mem_wr_addr, mem_wr_data;

    always #5 clk = ~clk;

    cache_refill_unit #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .busy(busy), .done(done),
        .line_write_en(line_write_en), .line_valid_in(line_valid_in),
        .line_dirty_in(line_dirty_in), .line_tag_in(line_tag_in),
        .line_offset(line_offset), .line_byte_en(line_byte_en),
        .line_data_in(line_data_in), .line_data_out(line_data_out),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ready(mem_rd_ready), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_ready(mem_wr_ready), .mem_wr_valid(mem_wr_valid),
        .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last),
        .mem_wr_data_ready(mem_wr_data_ready), .mem_wr_done(mem_wr_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model shared by the responder and the compare process
    int            txn_id = 0;
    logic          cur_dirty = 1'b0;
    logic [TW-1:0] cur_tag = '0;
    logic [31:0]   exp_rd_addr = '0;
    logic [31:0]   exp_wr_addr = '0;
    logic          wb_resp_seen = 1'b0;
    logic [31:0]   seed_val [BL];
    int            seed_gen = 0;

    // Statistics gathered by the compare process for per-scenario pins
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
    int n_valid_wr, n_line_wr, n_wr_valid_cyc, n_wr_last_acc, n_wr_req_cyc;
    int done_cnt, done_cyc, last_line_wr_cyc;

    function automatic logic [31:0] rd_word(input int k);
        return 32'hC0DE_0000 | (32'(txn_id) << 8) | 32'(k);
    endfunction

    // Line RAM: write and registered read, one cycle of latency
    initial begin
        logic [31:0] lmem [BL];
        int          my_gen;
        int          o;
        logic        w;
        logic [31:0] d;
        my_gen = 0;
        for (int k = 0; k < BL; k++) lmem[k] = '0;
        line_data_out = '0;
        forever begin
            @(negedge clk);
            o = int'(line_offset);
            w = line_write_en;
            d = line_data_in;
            @(posedge clk);
            #1;
            if (my_gen != seed_gen) begin
                for (int k = 0; k < BL; k++) lmem[k] = seed_val[k];
                my_gen = seed_gen;
            end
            line_data_out = lmem[o];
            if (w) lmem[o] = d;
        end
    end

    // Compare process: checks DUT outputs against the model every cycle
    int   cyc_n = 0;
    int   line_k = 0;
    int   wb_k = 0;
    logic in_txn = 1'b0;
    logic exp_done = 1'b0;

    initial begin
        logic nd;
        forever begin
            @(negedge clk);
            cyc_n++;
            nd = 1'b0;
            if (!rst) begin
                in_txn   = 1'b0;
                exp_done = 1'b0;
                line_k   = 0;
                wb_k     = 0;
            end else begin
                check("busy", busy, in_txn);
                check("done", done, exp_done);
                check("byte_en", line_byte_en, line_write_en ? 4'hf : 4'h0);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc_n;
                end
                if (line_write_en) begin
                    check("line_offset", line_offset, line_k);
                    check("line_data", line_data_in, rd_word(line_k));
                    check("line_valid", line_valid_in, line_k == BL - 1);
                    check("line_tag", line_tag_in, cur_tag);
                    check("line_dirty", line_dirty_in, 0);
                    if (line_valid_in) n_valid_wr++;
                    n_line_wr++;
                    last_line_wr_cyc = cyc_n;
                    line_k++;
                    if (line_k == BL) nd = 1'b1;
                end
                if (mem_wr_req) begin
                    n_wr_req_cyc++;
                    last_wr_addr = mem_wr_addr;
                    check("wr_addr", mem_wr_addr, exp_wr_addr);
                    check("wr_req_dirty", cur_dirty, 1);
                end
                if (mem_rd_req) begin
                    last_rd_addr = mem_rd_addr;
                    check("rd_addr", mem_rd_addr, exp_rd_addr);
                    check("rf_after_wb", !cur_dirty || wb_resp_seen, 1);
                end
                if (mem_wr_valid) begin
                    n_wr_valid_cyc++;
                    check("wr_data", mem_wr_data, seed_val[wb_k % BL]);
                    check("wr_last", mem_wr_last, wb_k == BL - 1);
                    if (mem_wr_data_ready) begin
                        last_wr_data = mem_wr_data;
                        if (mem_wr_last) n_wr_last_acc++;
                        wb_k++;
                    end
                end
                if (exp_done) begin
                    in_txn = 1'b0;
                    check("line_writes", line_k, BL);
                    check("wb_beats", wb_k, cur_dirty ? BL : 0);
                end else if (!in_txn && miss_req) begin
                    in_txn = 1'b1;
                    line_k = 0;
                    wb_k   = 0;
                end
                exp_done = nd;
            end
        end
    end

    task automatic clear_bus();
        mem_rd_ready      = 1'b0;
        mem_rd_valid      = 1'b0;
        mem_rd_data       = '0;
        mem_wr_ready      = 1'b0;
        mem_wr_data_ready = 1'b0;
        mem_wr_done       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
        n_valid_wr = 0; n_line_wr = 0; n_wr_valid_cyc = 0; n_wr_last_acc = 0;
        n_wr_req_cyc = 0; done_cnt = 0; done_cyc = 0; last_line_wr_cyc = 0;
    endtask

    task automatic seed_line(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < BL; k++) seed_val[k] = base + 32'(k) * step;
        seed_gen++;
    endtask

    // Drives one miss and plays the memory side until done (or an abort)
    task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [TW-1:0] vtag,
                            input int stall_beat, input int stall_cyc, input bit sparse,
                            input int abort_beat, input bit hold_req, input bit pulse_mid);
        int wr_acc, rd_given, stall_left, resp_cnt, cyc;
        bit rd_open, done_seen, prev_wv, prev_wdr, prev_rreq, phase, pulsed;
        wr_acc = 0; rd_given = 0; stall_left = stall_cyc; resp_cnt = 0; cyc = 0;
        rd_open = 0; done_seen = 0; prev_wv = 0; prev_wdr = 0; prev_rreq = 0;
        phase = 0; pulsed = 0;
        txn_id++;
        cur_dirty    = dirty;
        cur_tag      = addr[31:12];
        exp_rd_addr  = addr & 32'hFFFF_FFC0;
        exp_wr_addr  = {vtag, 12'h000} | (addr & 32'h0000_0FC0);
        wb_resp_seen = 1'b0;
        miss_addr    = addr;
        victim_dirty = dirty;
        victim_tag   = vtag;
        miss_req     = 1'b1;
        while (!done_seen && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev_wv && prev_wdr) wr_acc++;
            if (prev_rreq) rd_open = 1;
            if (done) done_seen = 1;
            if (!hold_req) miss_req = 1'b0;
            if (pulse_mid && rd_given == 8 && !pulsed) begin
                miss_req = 1'b1;
                pulsed   = 1;
            end
            if (abort_beat >= 0 && mem_wr_valid && wr_acc == abort_beat) begin
                rst = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_wr_valid", mem_wr_valid, 0);
                check("rst_all_outputs", |{busy, done, line_write_en, line_valid_in, line_dirty_in,
                      line_tag_in, line_offset, line_byte_en, line_data_in, mem_rd_req, mem_rd_addr,
                      mem_wr_req, mem_wr_addr, mem_wr_valid, mem_wr_data, mem_wr_last}, 0);
                miss_req = 1'b0;
                clear_bus();
                idle(2);
                rst = 1'b1;
                return;
            end
            mem_wr_ready = mem_wr_req;
            mem_rd_ready = mem_rd_req;
            if (mem_wr_valid) begin
                if (wr_acc == stall_beat && stall_left > 0) begin
                    mem_wr_data_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_wr_data_ready = 1'b1;
                end
            end else begin
                mem_wr_data_ready = 1'b0;
            end
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
            if (rd_open && rd_given < BL) begin
                if (sparse) phase = !phase;
                if (!sparse || !phase) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = rd_word(rd_given);
                    rd_given++;
                end
            end
            mem_wr_done = 1'b0;
            if (wr_acc == BL && resp_cnt < 3) begin
                if (resp_cnt == 0) begin
                    // Stray beat while waiting for the write response
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = 32'hBAD0_BAD0;
                end
                if (resp_cnt == 2) begin
                    mem_wr_done  = 1'b1;
                    wb_resp_seen = 1'b1;
                end
                resp_cnt++;
            end
            prev_wv   = mem_wr_valid;
            prev_wdr  = mem_wr_data_ready;
            prev_rreq = mem_rd_req && mem_rd_ready;
        end
        check("done_seen", done_seen, 1);
        @(posedge clk);
        #1;
        miss_req = 1'b0;
        clear_bus();
    endtask

    initial begin
        miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0; victim_tag = '0;
        clear_bus();
        clear_stats();
        seed_line(32'h0, 32'h0);
        idle(2);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_outputs", |{line_write_en, line_tag_in, line_offset, line_byte_en, line_data_in,
              mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_valid, mem_wr_data, mem_wr_last}, 0);
        rst = 1'b1;
        idle(2);

        // Clean miss, full-rate refill
        clear_stats();
        run_miss(32'h1234_5678, 1'b0, 20'h0, -1, 0, 1'b0, -1, 1'b0, 1'b0);
        idle(3);
        check("clean_rd_addr", last_rd_addr, 32'h1234_5640);
        check("clean_no_wr_req", n_wr_req_cyc, 0);
        check("clean_valid_once", n_valid_wr, 1);
        check("clean_done_latency", done_cyc - last_line_wr_cyc, 1);
        check("clean_done_count", done_cnt, 1);

        // Dirty miss, line holds k*0x11
        seed_line(32'h0, 32'h11);
        clear_stats();
        run_miss(32'h5555_5640, 1'b1, 20'hABCDE, -1, 0, 1'b0, -1, 1'b0, 1'b0);
        idle(3);
        check("dirty_wr_addr", last_wr_addr, 32'hABCD_E640);
        check("dirty_last_data", last_wr_data, 32'h0000_00FF);
        check("dirty_last_once", n_wr_last_acc, 1);
        check("dirty_beat_cycles", n_wr_valid_cyc, 16);
        check("dirty_done_count", done_cnt, 1);

        // Write backpressure: beat 5 held for 3 extra cycles
        seed_line(32'h1000_0000, 32'h3);
        clear_stats();
        run_miss(32'h6666_6680, 1'b1, 20'h24680, 5, 3, 1'b0, -1, 1'b0, 1'b0);
        idle(3);
        check("bp_beat_cycles", n_wr_valid_cyc, 19);
        check("bp_last_data", last_wr_data, 32'h1000_002D);
        check("bp_done_count", done_cnt, 1);

        // Sparse read data on alternate cycles
        clear_stats();
        run_miss(32'h0F0F_0F0C, 1'b0, 20'h0, -1, 0, 1'b1, -1, 1'b0, 1'b0);
        idle(3);
        check("sparse_line_writes", n_line_wr, 16);
        check("sparse_done_latency", done_cyc - last_line_wr_cyc, 1);
        check("sparse_done_count", done_cnt, 1);

        // Reset in the middle of the writeback, then a fresh dirty miss
        seed_line(32'h7700_0000, 32'h101);
        clear_stats();
        run_miss(32'h7777_7700, 1'b1, 20'h11111, -1, 0, 1'b0, 7, 1'b0, 1'b0);
        idle(2);
        check("post_rst_busy", busy, 0);
        check("post_rst_no_done", done_cnt, 0);
        seed_line(32'h2000_0000, 32'h5);
        clear_stats();
        run_miss(32'h2222_2040, 1'b1, 20'h13579, -1, 0, 1'b0, -1, 1'b0, 1'b0);
        idle(3);
        check("restart_wr_addr", last_wr_addr, 32'h1357_9040);
        check("restart_last_data", last_wr_data, 32'h2000_004B);
        check("restart_beat_cycles", n_wr_valid_cyc, 16);
        check("restart_done_count", done_cnt, 1);

        // miss_req held through done, dropped the cycle after
        clear_stats();
        run_miss(32'h3333_3000, 1'b0, 20'h0, -1, 0, 1'b0, -1, 1'b1, 1'b0);
        idle(4);
        check("hold_done_count", done_cnt, 1);

        // Second request pulsed mid-refill is ignored
        clear_stats();
        run_miss(32'h4444_4440, 1'b0, 20'h0, -1, 0, 1'b0, -1, 1'b0, 1'b1);
        idle(4);
        check("pulse_done_count", done_cnt, 1);
        check("pulse_line_writes", n_line_wr, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
